key_debounce_multi: RTL and testbench

Parametrised multi-channel successor to the single-key debouncer. Debounces NUM_KEYS independent push buttons with selectable polarity, on one 50 MHz clock. Per channel it outputs a clean pressed level plus one-cycle press, release and long-press event pulses. It sits between the board button pins and the control FSMs that consume key events.

---
 rtl/key_debounce_multi.sv | 95 +++++++++
 tb/tb_key_debounce_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button debouncer: 2-flop sync, stability counter,
// and registered press/release/long-press event pulses per channel.
module key_debounce_multi #(
  parameter int unsigned NUM_KEYS   = 4,
  parameter int unsigned DELAY_CNT  = 1_000_000,
  parameter int unsigned LONG_CNT   = 50_000_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic                any_press
);

  localparam int unsigned DW = $clog2(DELAY_CNT + 1);
  localparam int unsigned LW = $clog2(LONG_CNT + 1);
  localparam logic [NUM_KEYS-1:0] IDLE_RAW = {NUM_KEYS{ACTIVE_LOW}};

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] act;

  // Synchronisers idle at the released pin level so reset never looks like a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= IDLE_RAW;
      sync2 <= IDLE_RAW;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign act = sync2 ^ IDLE_RAW;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    logic [DW-1:0] db_cnt;
    logic [LW-1:0] long_cnt;
    logic          state_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          accept;

    assign accept = (act[g] != state_q) && (db_cnt == DW'(DELAY_CNT - 1));

    // Debounce: only an unbroken run of disagreeing samples flips the state
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt    <= '0;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= accept & act[g];
        release_q <= accept & ~act[g];
        if (act[g] == state_q) begin
          db_cnt <= '0;
        end else if (accept) begin
          state_q <= act[g];
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end
    end

    // Long press: saturating hold counter; a release on the firing edge suppresses the pulse
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        long_cnt <= '0;
        long_q   <= 1'b0;
      end else begin
        long_q <= state_q && !accept && (long_cnt == LW'(LONG_CNT - 1));
        if (!state_q || accept) begin
          long_cnt <= '0;
        end else if (long_cnt != LW'(LONG_CNT)) begin
          long_cnt <= long_cnt + LW'(1);
        end
      end
    end

    assign key_state[g]   = state_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
    assign key_long[g]    = long_q;
  end

  assign any_press = |key_press;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: window/timestamp reference model checked every
// cycle, directed latency checks, then randomized key activity with a mid-run reset.
module tb_key_debounce_multi;

  localparam int unsigned NK = 2;
  localparam int unsigned DC = 8;
  localparam int unsigned LC = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_state;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;
  logic          any_press;

  always #5 clk = ~clk;

  key_debounce_multi #(
    .NUM_KEYS  (NK),
    .DELAY_CNT (DC),
    .LONG_CNT  (LC),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .any_press  (any_press)
  );

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int long_seen = 0;

  // Reference model: pressed history per edge, state and press age
  bit            hist [NK][DC+2];
  logic [NK-1:0] m_state;
  logic [NK-1:0] m_press;
  logic [NK-1:0] m_release;
  logic [NK-1:0] m_long;
  int            age [NK];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NK; c++) begin
      for (int j = 0; j < DC + 2; j++) hist[c][j] = 1'b0;
      age[c] = -1;
    end
    m_state = '0; m_press = '0; m_release = '0; m_long = '0;
  endtask

  // A flip is accepted at edge n when the pressed samples taken at edges n-2 .. n-DC-1
  // all disagree with the current state; long fires LC edges after the press edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        for (int c = 0; c < NK; c++) begin
          bit stable;
          for (int j = DC + 1; j > 0; j--) hist[c][j] = hist[c][j-1];
          hist[c][0] = ~key_in[c];
          stable = 1'b1;
          for (int j = 2; j <= DC + 1; j++)
            if (hist[c][j] == m_state[c]) stable = 1'b0;
          m_press[c]   = stable & ~m_state[c];
          m_release[c] = stable & m_state[c];
          if (stable) m_state[c] = ~m_state[c];
          if (m_press[c]) age[c] = 0;
          else if (m_release[c]) age[c] = -1;
          else if (age[c] >= 0) age[c]++;
          m_long[c] = (age[c] == LC);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      check("state", 32'(key_state), 32'(m_state));
      check("press", 32'(key_press), 32'(m_press));
      check("release", 32'(key_release), 32'(m_release));
      check("long", 32'(key_long), 32'(m_long));
      check("any_press", 32'(any_press), 32'(|m_press));
      if (|{key_press, key_release, key_long}) pulse_cnt++;
      if (|key_long) long_seen++;
    end
  end

  task automatic wait_bit(input int ch, input int kind, input int max, output int edges);
    logic [NK-1:0] v;
    edges = -1;
    for (int i = 1; i <= max && edges < 0; i++) begin
      @(negedge clk);
      case (kind)
        0:       v = key_press;
        1:       v = key_release;
        default: v = key_long;
      endcase
      if (v[ch]) edges = i;
    end
  endtask

  initial begin
    int e;
    int hold [NK];
    rst = 1'b1;
    key_in = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_state", 32'(key_state), 0);
    check("rst_pulses", 32'({key_press, key_release, key_long, any_press}), 0);
    pulse_cnt = 0;
    repeat (20) @(negedge clk);
    check("idle_pulses", pulse_cnt, 0);
    check("idle_state", 32'(key_state), 0);

    // Clean press on key 0, long press, then release
    key_in[0] = 1'b0;
    wait_bit(0, 0, 30, e);
    check("press_latency", e, 10);
    check("press_vec", 32'(key_press), 32'h1);
    check("press_state", 32'(key_state), 32'h1);
    check("press_any", 32'(any_press), 1);
    wait_bit(0, 2, 60, e);
    check("long_latency", e, 32);
    pulse_cnt = 0;
    repeat (40) @(negedge clk);
    check("long_once", pulse_cnt, 0);
    key_in[0] = 1'b1;
    wait_bit(0, 1, 30, e);
    check("release_latency", e, 10);
    check("release_state", 32'(key_state), 0);

    // Bounces one cycle short of acceptance
    pulse_cnt = 0;
    repeat (5) begin
      key_in[0] = 1'b0;
      repeat (7) @(negedge clk);
      key_in[0] = 1'b1;
      repeat (7) @(negedge clk);
    end
    check("bounce_pulses", pulse_cnt, 0);
    check("bounce_state", 32'(key_state), 0);
    key_in[0] = 1'b0;
    wait_bit(0, 0, 30, e);
    check("bounce_final", e, 10);

    // Short press: release accepted 30 edges after press, before long
    long_seen = 0;
    repeat (20) @(negedge clk);
    key_in[0] = 1'b1;
    wait_bit(0, 1, 30, e);
    check("short_release", e, 10);
    repeat (20) @(negedge clk);
    check("short_no_long", long_seen, 0);

    // Release accepted on exactly the edge long would fire
    key_in[0] = 1'b0;
    wait_bit(0, 0, 30, e);
    long_seen = 0;
    repeat (22) @(negedge clk);
    key_in[0] = 1'b1;
    wait_bit(0, 1, 30, e);
    check("tie_release", e, 10);
    repeat (10) @(negedge clk);
    check("tie_no_long", long_seen, 0);

    // Both keys together, then reset mid-hold
    key_in = 2'b00;
    wait_bit(0, 0, 30, e);
    check("dual_latency", e, 10);
    check("dual_press", 32'(key_press), 32'h3);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_state", 32'(key_state), 0);
    check("async_pulses", 32'({key_press, key_release, key_long, any_press}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_bit(0, 0, 30, e);
    check("repress_latency", e, 10);
    check("repress_vec", 32'(key_press), 32'h3);

    // Randomized activity with a mix of bounces and long holds
    key_in = '1;
    repeat (15) @(negedge clk);
    for (int c = 0; c < NK; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < NK; c++) begin
        if (hold[c] == 0) begin
          key_in[c] = ~key_in[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 45))
                                                : int'($urandom_range(1, 10));
        end else begin
          hold[c]--;
        end
      end
      if (cyc == 1500) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (60) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
